master_request_queue: RTL

Per-master ingress queue for AXI address-channel requests (AR or AW) entering the crossbar. It accepts requests by valid/ready handshake and decodes each address to a destination slave number. Requests are buffered in a circular FIFO. The head entry's emptiness and destination feed every per-slave forward arbiter, and the entry is popped once the granting slave path consumes it. One instance sits on each master port.

---
 rtl/xbar_pkg.sv | 28 ++
 rtl/xbar_addr_decoder.sv | 28 ++
 rtl/master_request_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar types: index widths and the queued address-channel request entry.
package xbar_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int NUM_SLAVES  = 2;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_LEN_W   = 8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MST_W = clog2_min1(NUM_MASTERS);
  localparam int SLV_W = clog2_min1(NUM_SLAVES);

  typedef logic [MST_W-1:0] mst_idx_t;
  typedef logic [SLV_W-1:0] slv_idx_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_LEN_W-1:0]  len;
    slv_idx_t              dest;
    logic                  decerr;
  } req_entry_t;

endpackage

// File: rtl/xbar_addr_decoder.sv
// Maps an address to its slave region; out-of-map addresses go to slave 0 with decerr set.
module xbar_addr_decoder #(
  parameter int slaves      = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int REGION_BITS = 28,
  parameter int DEST_W      = (slaves > 1) ? $clog2(slaves) : 1
) (
  input  logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DEST_W-1:0]     dest,
  output logic                  decerr
);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_map;

  assign idx    = s_addr >> REGION_BITS;
  assign in_map = idx < ADDR_WIDTH'(slaves);

  always_comb begin
    dest   = '0;
    decerr = 1'b1;
    if (in_map) begin
      dest   = idx[DEST_W-1:0];
      decerr = 1'b0;
    end
  end

endmodule

// File: rtl/master_request_queue.sv
// Per-master ingress FIFO for AR/AW requests; destination is decoded at push time
// and the head entry is presented combinationally to the per-slave arbiters.
module master_request_queue
  import xbar_pkg::*;
#(
  parameter int masters     = NUM_MASTERS,
  parameter int slaves      = NUM_SLAVES,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = AXI_ADDR_W,
  parameter int ID_WIDTH    = AXI_ID_W,
  parameter int REGION_BITS = 28
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   s_addr,
  input  logic [ID_WIDTH-1:0]     s_id,
  input  logic [7:0]              s_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    fifo_empty,
  output logic [SLV_W-1:0]        head_slave_dest,
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic [ID_WIDTH-1:0]     head_id,
  output logic [7:0]              head_len,
  output logic                    head_decerr,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry fields are sized by the package, so the instance must agree with it.
  if (masters != NUM_MASTERS || slaves != NUM_SLAVES ||
      ADDR_WIDTH != AXI_ADDR_W || ID_WIDTH != AXI_ID_W) begin : g_pkg_mismatch
    $error("master_request_queue parameters disagree with xbar_pkg");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("master_request_queue DEPTH must be a power of 2 >= 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  req_entry_t    mem_q [DEPTH];
  req_entry_t    new_entry, head;
  slv_idx_t      dec_dest;
  logic          dec_decerr;
  logic          full, empty, push, do_pop;

  xbar_addr_decoder #(
    .slaves      (slaves),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_BITS (REGION_BITS),
    .DEST_W      (SLV_W)
  ) u_dec (
    .s_addr (s_addr),
    .dest   (dec_dest),
    .decerr (dec_decerr)
  );

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign push   = s_valid & ~full;
  assign do_pop = pop & ~empty;

  assign wr_ptr_d = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    new_entry        = '0;
    new_entry.addr   = s_addr;
    new_entry.id     = s_id;
    new_entry.len    = s_len;
    new_entry.dest   = dec_dest;
    new_entry.decerr = dec_decerr;
  end

  // Storage is deliberately not reset; head is masked to zero while empty.
  always_ff @(posedge ACLK) begin
    if (ARESETn && push) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign s_ready         = ~full;
  assign fifo_empty      = empty;
  assign head_slave_dest = head.dest;
  assign head_addr       = head.addr;
  assign head_id         = head.id;
  assign head_len        = head.len;
  assign head_decerr     = head.decerr;
  assign count           = wr_ptr_q - rd_ptr_q;

endmodule
